// File: rtl/rr_decode_arbiter_pkg.sv
// Shared encodings and widths for the round-robin decode arbiter.
package rr_decode_arbiter_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_decode_arbiter_decoder_3to8.sv
// 3-to-8 one-hot decoder; output is all-zero while en is low.
module decoder_3to8
  import rr_decode_arbiter_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] sel,
  output logic [N_REQ-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 8 requesters with a bounded hold time; the grant
// vector is decoded from registered state only.
module rr_decode_arbiter
  import rr_decode_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] last;

  // First set request searching upward from last+1; the last owner is
  // visited at the very end, giving it lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] l);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = l;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'(int'(l) + k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      hold_cnt  <= '0;
      last      <= IDX_W'(N_REQ - 1);
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            grant_idx <= rr_pick(req, last);
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          // A dropped request wins over an expiring hold: no timeout then.
          if (!req[grant_idx]) begin
            state    <= IDLE;
            last     <= grant_idx;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= IDLE;
            last     <= grant_idx;
            hold_cnt <= '0;
            timeout  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == GRANT);

  decoder_3to8 u_dec (
    .en    (busy),
    .sel   (grant_idx),
    .onehot(grant)
  );
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios plus randomized traffic
// against an owner/held-cycles reference model.
module tb_rr_decode_arbiter;
  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .grant_idx(grant_idx),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the resource and for how many cycles so far.
  logic       m_busy;
  logic [2:0] m_idx;
  logic [2:0] m_last;
  int         m_held;
  logic       m_to;

  function automatic logic [2:0] winner(input logic [7:0] r, input logic [2:0] l);
    int best;
    int d;
    best   = 99;
    winner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) begin
        d = (i - int'(l) + 7) % 8;
        if (d < best) begin
          best   = d;
          winner = 3'(i);
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_idx  <= 3'd0;
      m_last <= 3'd7;
      m_held <= 0;
      m_to   <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!m_busy) begin
        if (req != 8'd0) begin
          m_busy <= 1'b1;
          m_idx  <= winner(req, m_last);
          m_held <= 1;
        end
      end else if (!req[m_idx]) begin
        m_busy <= 1'b0;
        m_last <= m_idx;
      end else if (m_held == MAX_HOLD) begin
        m_busy <= 1'b0;
        m_last <= m_idx;
        m_to   <= 1'b1;
      end else begin
        m_held <= m_held + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_grant", 32'(grant), m_busy ? 32'(1) << m_idx : 32'd0);
    check("model_idx", 32'(grant_idx), 32'(m_idx));
    check("model_busy", 32'(busy), 32'(m_busy));
    check("model_timeout", 32'(timeout), 32'(m_to));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 8'd0;
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int         period;
  logic [7:0] flips;

  initial begin
    rst = 1'b1;
    req = 8'd0;
    repeat (2) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Quiet bus after reset
    for (int c = 0; c < 10; c++) begin
      tick();
      check("quiet_grant", 32'(grant), 32'd0);
      check("quiet_busy", 32'(busy), 32'd0);
      check("quiet_timeout", 32'(timeout), 32'd0);
    end

    // Basic grant, release, one idle cycle, next grant
    req = 8'b0000_0101;
    tick();
    check("basic_grant0", 32'(grant), 32'h01);
    check("basic_idx0", 32'(grant_idx), 32'd0);
    check("basic_busy0", 32'(busy), 32'd1);
    req = 8'b0000_0100;
    tick();
    check("basic_gap", 32'(grant), 32'd0);
    tick();
    check("basic_grant2", 32'(grant), 32'h04);

    // Full round-robin rotation with wrap
    do_reset();
    req = 8'hFF;
    tick();
    for (int i = 0; i < 9; i++) begin
      check("rr_order", 32'(grant_idx), 32'(i % 8));
      check("rr_grant", 32'(grant), 32'(1) << (i % 8));
      req = 8'hFF & ~(8'd1 << grant_idx);
      tick();
      check("rr_gap", 32'(grant), 32'd0);
      req = 8'hFF;
      tick();
    end

    // Single requester held past the hold limit
    do_reset();
    req = 8'b0000_1000;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c <= 15) check("hold_grant", 32'(grant), 32'h08);
      if (c == 16) begin
        check("hold_to_grant", 32'(grant), 32'd0);
        check("hold_to_pulse", 32'(timeout), 32'd1);
      end
      if (c == 17) begin
        check("hold_regrant", 32'(grant), 32'h08);
        check("hold_to_low", 32'(timeout), 32'd0);
      end
    end

    // Timed-out owner yields to the next requester
    do_reset();
    req = 8'b0001_1000;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1 || c == 15) check("yield_first", 32'(grant), 32'h08);
      if (c == 16) check("yield_to", 32'(timeout), 32'd1);
      if (c == 17) check("yield_next", 32'(grant), 32'h10);
    end

    // Release on the last allowed cycle is a normal release
    do_reset();
    req = 8'b0000_1000;
    repeat (15) tick();
    check("edge_held", 32'(grant), 32'h08);
    req = 8'd0;
    tick();
    check("edge_grant", 32'(grant), 32'd0);
    check("edge_timeout", 32'(timeout), 32'd0);

    // Asynchronous reset in the middle of a grant
    do_reset();
    req = 8'b0010_0000;
    tick();
    check("mid_grant5", 32'(grant), 32'h20);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_timeout", 32'(timeout), 32'd0);
    tick();
    req = 8'b1010_0000;
    rst = 1'b0;
    tick();
    check("mid_after_rst", 32'(grant), 32'h20);

    // Randomized traffic with slow and fast-changing request segments
    do_reset();
    period = 3;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) period = ($urandom_range(0, 1) == 0) ? 3 : 40;
      flips = 8'd0;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, period - 1) == 0) flips[b] = 1'b1;
      req = req ^ flips;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    req = 8'd0;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
